// File: rtl/uc_arbiter_multi_if.sv
// ============================================================================
//  Module      : uc_arbiter_multi_if
//  Description : Literal handshake bundle between the unit-clause arbiter and
//                its sources/sinks: memory preload, per-engine UCQ_in heads
//                (FWFT), per-engine UCQ_out full flags, and the broadcast push.
//  Ports       : mem2uca/_valid/_done  preload literal stream
//                eng2uca_lit/_empty    packed UCQ_in heads and empty flags
//                eng2uca_full          UCQ_out full flags
//                uca2eng_pop           one-hot UCQ_in pop
//                uca2eng_push/_lit     broadcast push to every UCQ_out
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uc_arbiter_multi_if #(
  parameter int NUM_ENG = 4,
  parameter int LIT_W   = 8
);
  logic [LIT_W-1:0]         mem2uca;
  logic                     mem2uca_valid;
  logic                     mem2uca_done;
  logic [NUM_ENG*LIT_W-1:0] eng2uca_lit;
  logic [NUM_ENG-1:0]       eng2uca_empty;
  logic [NUM_ENG-1:0]       eng2uca_full;
  logic [NUM_ENG-1:0]       uca2eng_pop;
  logic                     uca2eng_push;
  logic [LIT_W-1:0]         uca2eng_lit;

  // Environment side: memory preload and engine queues.
  modport master (
    output mem2uca, mem2uca_valid, mem2uca_done,
    output eng2uca_lit, eng2uca_empty, eng2uca_full,
    input  uca2eng_pop, uca2eng_push, uca2eng_lit
  );

  // Arbiter side.
  modport slave (
    input  mem2uca, mem2uca_valid, mem2uca_done,
    input  eng2uca_lit, eng2uca_empty, eng2uca_full,
    output uca2eng_pop, uca2eng_push, uca2eng_lit
  );
endinterface

`default_nettype wire

// File: rtl/uc_arbiter_multi.sv
// ============================================================================
//  Module      : uc_arbiter_multi
//  Description : Unit-clause arbiter fused with the assignment trail. Merges
//                preload and round-robin engine literals, tracks per-variable
//                assignments, flags conflicts, pushes new assignments onto a
//                trail stack and broadcasts them to every engine.
//  Ports       : clk, rst               clock, async active-high reset
//                halt_i                 freeze arbitration while in RUN
//                clear_conflict_i       leave CONFLICT
//                bus                    literal handshake (slave modport)
//                mstack_pop_i           pop trail top (unassigns its variable)
//                mstack_lit_o           trail top literal, 0 when empty
//                mstack_empty_o/full_o  trail status
//                conflict_o/_lit_o      sticky conflict flag and culprit
//                state_o                FSM state (LOAD/RUN/HALTED/CONFLICT)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uc_arbiter_multi #(
  parameter int NUM_ENG     = 4,
  parameter int LIT_W       = 8,
  parameter int STACK_DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt_i,
  input  logic             clear_conflict_i,
  uc_arbiter_multi_if.slave bus,
  input  logic             mstack_pop_i,
  output logic [LIT_W-1:0] mstack_lit_o,
  output logic             mstack_empty_o,
  output logic             mstack_full_o,
  output logic             conflict_o,
  output logic [LIT_W-1:0] conflict_lit_o,
  output logic [1:0]       state_o
);

  localparam int VARS  = 1 << (LIT_W - 1);
  localparam int PTR_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  localparam int AW    = $clog2(STACK_DEPTH);
  localparam int SP_W  = AW + 1;

  typedef enum logic [1:0] {
    S_LOAD     = 2'd0,
    S_RUN      = 2'd1,
    S_HALTED   = 2'd2,
    S_CONFLICT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SP_W-1:0]    sp_q;
  logic [VARS-1:0]    assigned_q;
  logic [VARS-1:0]    val_q;
  logic               conflict_q;
  logic [LIT_W-1:0]   conflict_lit_q;
  logic [LIT_W-1:0]   stack_q [STACK_DEPTH];

  logic               stall;
  logic               cand_valid;
  logic [LIT_W-1:0]   cand_lit;
  logic [LIT_W-2:0]   cand_var;
  logic               cand_neg;
  logic [NUM_ENG-1:0] eng_pop;
  logic               do_push;
  logic               do_conflict;
  logic               grant_found;
  int                 grant_idx;
  int                 scan_idx;
  int                 next_ptr;

  logic [AW-1:0]      top_idx;
  logic [LIT_W-1:0]   top_lit;
  logic [LIT_W-2:0]   top_var;

  // Trail top view; top_idx wraps harmlessly when sp==0 since the output is masked.
  assign top_idx        = AW'(sp_q - SP_W'(1));
  assign top_lit        = stack_q[top_idx];
  assign top_var        = top_lit[LIT_W-1:1];
  assign mstack_empty_o = (sp_q == '0);
  assign mstack_full_o  = (sp_q == SP_W'(STACK_DEPTH));
  assign mstack_lit_o   = mstack_empty_o ? '0 : top_lit;

  // A pending trail pop owns the cycle; full downstream or full trail also blocks.
  assign stall = (|bus.eng2uca_full) | mstack_full_o | mstack_pop_i;

  assign cand_var = cand_lit[LIT_W-1:1];
  assign cand_neg = cand_lit[0];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cand_valid  = 1'b0;
    cand_lit    = '0;
    eng_pop     = '0;
    grant_found = 1'b0;
    grant_idx   = 0;
    scan_idx    = 0;
    next_ptr    = 0;

    case (state_q)
      S_LOAD: begin
        if (bus.mem2uca_valid && !stall) begin
          cand_valid = 1'b1;
          cand_lit   = bus.mem2uca;
        end
        if (bus.mem2uca_done) state_d = S_RUN;
      end
      S_RUN: begin
        if (halt_i) begin
          state_d = S_HALTED;
        end else if (!stall) begin
          // First non-empty engine at or after rr_ptr, wrapping.
          for (int k = 0; k < NUM_ENG; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NUM_ENG) scan_idx = scan_idx - NUM_ENG;
            if (!grant_found && !bus.eng2uca_empty[scan_idx]) begin
              grant_found = 1'b1;
              grant_idx   = scan_idx;
            end
          end
          if (grant_found) begin
            cand_valid          = 1'b1;
            cand_lit            = bus.eng2uca_lit[grant_idx*LIT_W +: LIT_W];
            eng_pop[grant_idx]  = 1'b1;
            next_ptr            = grant_idx + 1;
            if (next_ptr >= NUM_ENG) next_ptr = 0;
            rr_ptr_d            = PTR_W'(next_ptr);
          end
        end
      end
      S_HALTED: begin
        if (!halt_i) state_d = S_RUN;
      end
      default: begin
        if (clear_conflict_i) state_d = S_RUN;
      end
    endcase

    // Decision against the table as of this cycle; updates land at the edge.
    do_push     = 1'b0;
    do_conflict = 1'b0;
    if (cand_valid && (cand_var != '0)) begin
      if (!assigned_q[cand_var])            do_push     = 1'b1;
      else if (val_q[cand_var] == cand_neg) do_conflict = 1'b1;
    end
    if (do_conflict) state_d = S_CONFLICT;
  end

  assign bus.uca2eng_pop  = eng_pop;
  assign bus.uca2eng_push = do_push;
  assign bus.uca2eng_lit  = do_push ? cand_lit : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_LOAD;
      rr_ptr_q       <= '0;
      sp_q           <= '0;
      assigned_q     <= '0;
      val_q          <= '0;
      conflict_q     <= 1'b0;
      conflict_lit_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      // Pop and push are mutually exclusive because a pop stalls arbitration.
      if (mstack_pop_i && !mstack_empty_o) begin
        sp_q                <= sp_q - SP_W'(1);
        assigned_q[top_var] <= 1'b0;
      end else if (do_push) begin
        sp_q                 <= sp_q + SP_W'(1);
        assigned_q[cand_var] <= 1'b1;
        val_q[cand_var]      <= ~cand_neg;
      end
      if (do_conflict) begin
        conflict_q     <= 1'b1;
        conflict_lit_q <= cand_lit;
      end else if (state_q == S_CONFLICT && clear_conflict_i) begin
        conflict_q     <= 1'b0;
        conflict_lit_q <= '0;
      end
    end
  end

  // Trail storage needs no reset: entries above sp are never observed.
  always_ff @(posedge clk) begin
    if (do_push) stack_q[sp_q[AW-1:0]] <= cand_lit;
  end

  assign conflict_o     = conflict_q;
  assign conflict_lit_o = conflict_lit_q;
  assign state_o        = state_q;

endmodule

`default_nettype wire

// File: tb/tb_uc_arbiter_multi.sv
// ============================================================================
//  Module      : tb_uc_arbiter_multi
//  Description : Directed self-checking bench for uc_arbiter_multi
//                (NUM_ENG=4, LIT_W=8, STACK_DEPTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uc_arbiter_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       halt;
  logic       clr;
  logic       mpop;
  logic [7:0] mstack_lit;
  logic       mstack_empty;
  logic       mstack_full;
  logic       conflict;
  logic [7:0] conflict_lit;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  uc_arbiter_multi_if #(.NUM_ENG(4), .LIT_W(8)) bus ();

  uc_arbiter_multi #(.NUM_ENG(4), .LIT_W(8), .STACK_DEPTH(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .halt_i           (halt),
    .clear_conflict_i (clr),
    .bus              (bus),
    .mstack_pop_i     (mpop),
    .mstack_lit_o     (mstack_lit),
    .mstack_empty_o   (mstack_empty),
    .mstack_full_o    (mstack_full),
    .conflict_o       (conflict),
    .conflict_lit_o   (conflict_lit),
    .state_o          (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_eng(input int e, input logic [7:0] lit);
    bus.eng2uca_lit[e*8 +: 8] = lit;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rr_exp [5];
    rr_exp[0] = 8'h20; rr_exp[1] = 8'h2A; rr_exp[2] = 8'h34;
    rr_exp[3] = 8'h3E; rr_exp[4] = 8'h40;

    rst = 1'b1; halt = 1'b0; clr = 1'b0; mpop = 1'b0;
    bus.mem2uca = '0; bus.mem2uca_valid = 1'b0; bus.mem2uca_done = 1'b0;
    bus.eng2uca_lit = '0; bus.eng2uca_empty = 4'hF; bus.eng2uca_full = 4'h0;
    #2;
    chk("rst_state", state, 0);
    chk("rst_empty", mstack_empty, 1);
    chk("rst_full", mstack_full, 0);
    chk("rst_conflict", conflict, 0);
    chk("rst_clit", conflict_lit, 0);
    chk("rst_push", bus.uca2eng_push, 0);
    chk("rst_pop", bus.uca2eng_pop, 0);
    chk("rst_mlit", mstack_lit, 0);
    cyc();
    rst = 1'b0;

    // Pop on an empty trail is ignored.
    mpop = 1'b1;
    cyc();
    mpop = 1'b0;
    chk("emptypop_empty", mstack_empty, 1);
    chk("emptypop_state", state, 0);

    // Preload 04, 06, then 05 together with done.
    bus.mem2uca_valid = 1'b1; bus.mem2uca = 8'h04;
    @(negedge clk);
    chk("pre0_push", bus.uca2eng_push, 1);
    chk("pre0_lit", bus.uca2eng_lit, 8'h04);
    cyc();
    bus.mem2uca = 8'h06;
    @(negedge clk);
    chk("pre1_push", bus.uca2eng_push, 1);
    chk("pre1_lit", bus.uca2eng_lit, 8'h06);
    cyc();
    bus.mem2uca = 8'h05; bus.mem2uca_done = 1'b1;
    @(negedge clk);
    chk("pre2_push", bus.uca2eng_push, 0);
    cyc();
    bus.mem2uca_valid = 1'b0; bus.mem2uca_done = 1'b0;
    chk("pre_conflict", conflict, 1);
    chk("pre_clit", conflict_lit, 8'h05);
    chk("pre_state", state, 3);
    chk("pre_mlit", mstack_lit, 8'h06);

    // Trail pops honoured in CONFLICT, then clear.
    mpop = 1'b1;
    cyc();
    chk("cpop1_mlit", mstack_lit, 8'h04);
    cyc();
    mpop = 1'b0;
    chk("cpop2_empty", mstack_empty, 1);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr_state", state, 1);
    chk("clr_conflict", conflict, 0);
    chk("clr_clit", conflict_lit, 0);

    // Round robin with all engines non-empty, rr_ptr=0.
    bus.eng2uca_empty = 4'h0;
    for (int k = 0; k < 5; k++) begin
      for (int e = 0; e < 4; e++) set_eng(e, 8'((16 + k*4 + e) << 1));
      @(negedge clk);
      chk($sformatf("rr%0d_pop", k), bus.uca2eng_pop, 32'(1 << (k % 4)));
      chk($sformatf("rr%0d_push", k), bus.uca2eng_push, 1);
      chk($sformatf("rr%0d_lit", k), bus.uca2eng_lit, rr_exp[k]);
      cyc();
    end
    bus.eng2uca_empty = 4'hF;

    // Duplicate literal from two engines on consecutive cycles.
    bus.eng2uca_empty = 4'b1110; set_eng(0, 8'h08);
    @(negedge clk);
    chk("dup0_pop", bus.uca2eng_pop, 4'b0001);
    chk("dup0_push", bus.uca2eng_push, 1);
    chk("dup0_lit", bus.uca2eng_lit, 8'h08);
    cyc();
    bus.eng2uca_empty = 4'b1101; set_eng(1, 8'h08);
    @(negedge clk);
    chk("dup1_pop", bus.uca2eng_pop, 4'b0010);
    chk("dup1_push", bus.uca2eng_push, 0);
    cyc();

    // Backpressure: UCQ_out[2] full for three cycles; rr_ptr stays at 2.
    bus.eng2uca_empty = 4'b0011; set_eng(2, 8'h0C); set_eng(3, 8'h0E);
    bus.eng2uca_full = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_pop", i), bus.uca2eng_pop, 0);
      chk($sformatf("bp%0d_push", i), bus.uca2eng_push, 0);
      cyc();
    end
    bus.eng2uca_full = 4'b0000;
    @(negedge clk);
    chk("bpres_pop", bus.uca2eng_pop, 4'b0100);
    chk("bpres_lit", bus.uca2eng_lit, 8'h0C);
    cyc();

    // Halt: no grant in the halt cycle nor in the HALTED exit cycle.
    bus.eng2uca_empty = 4'b0111; set_eng(3, 8'h0A);
    halt = 1'b1;
    @(negedge clk);
    chk("halt_pop", bus.uca2eng_pop, 0);
    chk("halt_push", bus.uca2eng_push, 0);
    cyc();
    chk("halt_state", state, 2);
    halt = 1'b0;
    @(negedge clk);
    chk("unhalt_pop", bus.uca2eng_pop, 0);
    cyc();
    chk("unhalt_state", state, 1);

    // Backtrack: a trail pop has priority over a pending engine literal.
    mpop = 1'b1;
    @(negedge clk);
    chk("bt_pop_stall", bus.uca2eng_pop, 0);
    chk("bt_mlit_before", mstack_lit, 8'h0C);
    cyc();
    mpop = 1'b0;
    chk("bt_mlit_after", mstack_lit, 8'h08);
    @(negedge clk);
    chk("bt_0A_pop", bus.uca2eng_pop, 4'b1000);
    chk("bt_0A_lit", bus.uca2eng_lit, 8'h0A);
    cyc();
    chk("bt_0A_top", mstack_lit, 8'h0A);
    bus.eng2uca_empty = 4'hF;
    mpop = 1'b1;
    cyc();
    mpop = 1'b0;
    chk("bt_unpush_top", mstack_lit, 8'h08);
    bus.eng2uca_empty = 4'b1110; set_eng(0, 8'h0B);
    @(negedge clk);
    chk("bt_0B_push", bus.uca2eng_push, 1);
    chk("bt_0B_lit", bus.uca2eng_lit, 8'h0B);
    cyc();

    // Fill the trail, then a pending literal must stall.
    bus.eng2uca_empty = 4'b1101; set_eng(1, 8'h50);
    @(negedge clk);
    chk("fill_lit", bus.uca2eng_lit, 8'h50);
    cyc();
    chk("fill_full", mstack_full, 1);
    bus.eng2uca_empty = 4'b1011; set_eng(2, 8'h52);
    @(negedge clk);
    chk("full_pop", bus.uca2eng_pop, 0);
    chk("full_push", bus.uca2eng_push, 0);
    cyc();
    chk("full_top", mstack_lit, 8'h50);

    // Asynchronous reset mid-run takes effect without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", state, 0);
    chk("arst_empty", mstack_empty, 1);
    chk("arst_full", mstack_full, 0);
    chk("arst_conflict", conflict, 0);
    cyc();
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uc_arbiter_multi.md
Name: uc_arbiter_multi

Overview:
- Parametrised successor to the fixed-engine unit-clause path. Fuses the UC arbiter and the assignment stack into one block.
- Merges unit literals from the memory preload and from NUM_ENG engine UCQ_in queues, using fair round-robin across engines.
- Keeps a per-variable assignment table, detects duplicate and conflicting literals, and pushes new assignments onto a trail stack.
- Broadcasts each accepted literal to every engine's UCQ_out. Supports stack pop with variable unassignment for backtracking.

Parameters:
- NUM_ENG, 4: number of BCP engines (≥1).
- LIT_W, 8: literal width; literal = {var[LIT_W-2:0], neg}; var 0 is reserved, so literal 0/1 is invalid.
- STACK_DEPTH, 64: trail stack entries (power of 2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- halt  in  1  freeze arbitration.
- clear_conflict  in  1  leave CONFLICT state.
- mem2uca  in  LIT_W  preload literal.
- mem2uca_valid  in  1  preload literal valid.
- mem2uca_done  in  1  preload complete.
- eng2uca_lit  in  NUM_ENG*LIT_W  head of each UCQ_in (FWFT).
- eng2uca_empty  in  NUM_ENG  UCQ_in empty.
- eng2uca_full  in  NUM_ENG  UCQ_out full.
- uca2eng_pop  out  NUM_ENG  one-hot UCQ_in pop.
- uca2eng_push  out  1  broadcast push to all UCQ_out.
- uca2eng_lit  out  LIT_W  broadcast literal.
- mstack_pop  in  1  pop trail top.
- mstack_lit  out  LIT_W  trail top literal (0 when empty).
- mstack_empty  out  1  trail empty.
- mstack_full  out  1  trail full.
- conflict  out  1  sticky conflict flag.
- conflict_lit  out  LIT_W  literal that caused the conflict.
- state_o  out  2  FSM state.

Behaviour:

FSM states: LOAD=0, RUN=1, HALTED=2, CONFLICT=3. Reset enters LOAD.
- LOAD: the candidate is mem2uca when mem2uca_valid; engines are never granted. On mem2uca_done go to RUN; a valid literal in the same cycle is still processed.
- RUN: the candidate is the engine granted by round-robin among engines with !eng2uca_empty. The search starts at rr_ptr; after a grant, rr_ptr = granted+1 mod NUM_ENG; with no grant, rr_ptr holds.
- RUN -> HALTED when halt=1; no grant or push in the halt cycle. HALTED -> RUN when halt=0. halt in LOAD is ignored.
- CONFLICT: no grants, no pushes; mstack_pop is still honoured. clear_conflict=1 goes to RUN and clears conflict and conflict_lit.

Stall (no grant, no pop/push) when any of the following holds: |eng2uca_full; mstack_full; mstack_pop=1 in the same cycle (pop has priority).

Candidate processing (combinational decide; table and stack update at the clock edge):
- Invalid literal (var==0): pop the source and drop it.
- Variable unassigned: pop the source, uca2eng_push=1, uca2eng_lit=literal, push to the stack, and set assigned with val=~neg.
- Assigned, same polarity: pop the source, drop it, no push.
- Assigned, opposite polarity: pop the source, no push; conflict<=1, conflict_lit<=literal, state<=CONFLICT.

Timing and hazards:
- Pop and push are asserted in the same cycle as the decision; accept-to-push latency is 0 cycles.
- The table update is visible the next cycle, so back-to-back same-variable literals are resolved correctly.
- At most one literal is accepted per cycle.

Trail stack:
- Pointer sp counts 0..STACK_DEPTH. mstack_lit = entry[sp-1] combinationally, or 0 when sp==0.
- mstack_pop with sp>0: sp--, and the popped variable's assigned bit is cleared at the same edge.
- mstack_pop with sp==0: ignored, no state change.

Reset (asynchronous):
- State and counters: state=LOAD, sp=0, rr_ptr=0.
- Assignment table cleared.
- Flags: conflict=0, conflict_lit=0.
- Outputs: all push and pop outputs 0; mstack_empty=1, mstack_full=0.
- Reset asserted mid-operation discards all in-flight decisions.

Test Plan:
- Preload: mem literals 0x04, 0x06, 0x05 then done → two pushes (0x04, 0x06); 0x05 raises conflict=1, conflict_lit=0x05, state=3, no push for 0x05.
- RR fairness, NUM_ENG=4: all engines non-empty with distinct vars, rr_ptr=0 → grants 0,1,2,3,0 on consecutive cycles; each grant paired with a push.
- Duplicate: eng0 sends 0x08, eng1 sends 0x08 the next cycle → one push; both queues popped.
- Backpressure: eng2uca_full[2]=1 for 3 cycles → no pops or pushes in those cycles; resumes the cycle after deassertion with the same rr_ptr.
- Backtrack: push 0x0A, then mstack_pop (mstack_lit=0x0A, sp 1→0), then an engine sends 0x0B → accepted (variable was unassigned by the pop); a pop on an empty stack does nothing.
- Stack full at STACK_DEPTH with a new literal pending → stall, mstack_full=1; an async rst mid-run → state=0, mstack_empty=1, conflict=0 immediately.
